// File: rtl/msrv32_integer_file_if.sv
// Register-file access bus: two combinational read ports and one write port.
// The core drives it through master; the register file receives it through slave.
interface msrv32_integer_file_if;
    logic [4:0]  rs_1_addr_in;
    logic [4:0]  rs_2_addr_in;
    logic [4:0]  rd_addr_in;
    logic        wr_en_in;
    logic [31:0] rd_in;
    logic [31:0] rs_1_out;
    logic [31:0] rs_2_out;

    modport master (
        output rs_1_addr_in,
        output rs_2_addr_in,
        output rd_addr_in,
        output wr_en_in,
        output rd_in,
        input  rs_1_out,
        input  rs_2_out
    );

    modport slave (
        input  rs_1_addr_in,
        input  rs_2_addr_in,
        input  rd_addr_in,
        input  wr_en_in,
        input  rd_in,
        output rs_1_out,
        output rs_2_out
    );
endinterface

// File: rtl/msrv32_integer_file.sv
// RV32I integer register file: x1..x31 in flops, x0 hardwired to zero, two async read ports.
// Define MSRV32_RF_WRITE_BYPASS_EN to forward same-cycle write data to matching read ports.
module msrv32_integer_file (
    input  logic                        ms_riscv32_mp_clk_in,
    input  logic                        ms_riscv32_mp_rst_in,
    msrv32_integer_file_if.slave        rf_bus
);

    // No entry for x0; reads of index 0 fall through to the zero default below.
    logic [31:0] regs_reg [1:31];
    logic [31:1] wr_sel;
    logic [31:0] rs_1_stored;
    logic [31:0] rs_2_stored;

    // One-hot write decode; index 0 never matches, so x0 writes are discarded.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_wr_dec
            assign wr_sel[gi] = rf_bus.wr_en_in && (rf_bus.rd_addr_in == 5'(gi));
        end
    endgenerate

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        for (int i = 1; i < 32; i++) begin
            if (ms_riscv32_mp_rst_in) begin
                regs_reg[i] <= '0;
            end else if (wr_sel[i]) begin
                regs_reg[i] <= rf_bus.rd_in;
            end
        end
    end

    always_comb begin
        rs_1_stored = '0;
        rs_2_stored = '0;
        for (int i = 1; i < 32; i++) begin
            if (rf_bus.rs_1_addr_in == 5'(i)) begin
                rs_1_stored = regs_reg[i];
            end
            if (rf_bus.rs_2_addr_in == 5'(i)) begin
                rs_2_stored = regs_reg[i];
            end
        end
    end

`ifdef MSRV32_RF_WRITE_BYPASS_EN
    // Forwarding is blocked during reset so the outputs track the cleared contents.
    logic bypass_ok;
    assign bypass_ok = rf_bus.wr_en_in && !ms_riscv32_mp_rst_in && (rf_bus.rd_addr_in != 5'd0);

    assign rf_bus.rs_1_out = (bypass_ok && (rf_bus.rs_1_addr_in == rf_bus.rd_addr_in))
                             ? rf_bus.rd_in : rs_1_stored;
    assign rf_bus.rs_2_out = (bypass_ok && (rf_bus.rs_2_addr_in == rf_bus.rd_addr_in))
                             ? rf_bus.rd_in : rs_2_stored;
`else
    assign rf_bus.rs_1_out = rs_1_stored;
    assign rf_bus.rs_2_out = rs_2_stored;
`endif

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Directed self-checking bench for msrv32_integer_file (either bypass build).
module tb_msrv32_integer_file;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    msrv32_integer_file_if rf_if ();

    msrv32_integer_file dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .rf_bus               (rf_if.slave)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; reads are taken mid-cycle.
    task automatic write_cycle(input logic [4:0] addr, input logic [31:0] data, input logic en);
        rf_if.rd_addr_in = addr;
        rf_if.rd_in      = data;
        rf_if.wr_en_in   = en;
        @(posedge clk);
        #1;
        rf_if.wr_en_in   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rf_if.wr_en_in   = 1'b1;
        rf_if.rd_addr_in = 5'd3;
        rf_if.rd_in      = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        // Reset still high with a write presented: outputs must read stored zeros.
        for (int i = 0; i < 32; i++) begin
            rf_if.rs_1_addr_in = 5'(i);
            rf_if.rs_2_addr_in = 5'(i);
            #1;
            vectors++;
            if (rf_if.rs_1_out !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_rs1[%0d] got %h exp %h", i, rf_if.rs_1_out, 32'h0);
            end
            vectors++;
            if (rf_if.rs_2_out !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_rs2[%0d] got %h exp %h", i, rf_if.rs_2_out, 32'h0);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rf_if.wr_en_in = 1'b0;
        $display("reset: all 32 indices checked on both ports");
    endtask

    task automatic test_write_read;
        write_cycle(5'd5, 32'hDEADBEEF, 1'b1);
        rf_if.rs_1_addr_in = 5'd5;
        rf_if.rs_2_addr_in = 5'd5;
        #1;
        vectors++;
        if (rf_if.rs_1_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wr_x5_rs1 got %h exp %h", rf_if.rs_1_out, 32'hDEADBEEF);
        end
        vectors++;
        if (rf_if.rs_2_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wr_x5_rs2 got %h exp %h", rf_if.rs_2_out, 32'hDEADBEEF);
        end
        $display("write_read: x5 <= deadbeef, rs1=%h rs2=%h", rf_if.rs_1_out, rf_if.rs_2_out);
    endtask

    task automatic test_x0;
        rf_if.wr_en_in     = 1'b1;
        rf_if.rd_addr_in   = 5'd0;
        rf_if.rd_in        = 32'hFFFFFFFF;
        rf_if.rs_1_addr_in = 5'd0;
        rf_if.rs_2_addr_in = 5'd0;
        #1;
        vectors++;
        if (rf_if.rs_1_out !== 32'h0) begin
            miscompares++;
            $display("FAIL x0_same_cycle got %h exp %h", rf_if.rs_1_out, 32'h0);
        end
        @(posedge clk);
        #1;
        rf_if.wr_en_in = 1'b0;
        #1;
        vectors++;
        if (rf_if.rs_1_out !== 32'h0) begin
            miscompares++;
            $display("FAIL x0_next_cycle_rs1 got %h exp %h", rf_if.rs_1_out, 32'h0);
        end
        vectors++;
        if (rf_if.rs_2_out !== 32'h0) begin
            miscompares++;
            $display("FAIL x0_next_cycle_rs2 got %h exp %h", rf_if.rs_2_out, 32'h0);
        end
        $display("x0: write ffffffff discarded, rs1=%h", rf_if.rs_1_out);
    endtask

    task automatic test_same_cycle;
        logic [31:0] exp_same;
`ifdef MSRV32_RF_WRITE_BYPASS_EN
        exp_same = 32'h22222222;
`else
        exp_same = 32'h11111111;
`endif
        write_cycle(5'd7, 32'h11111111, 1'b1);
        rf_if.wr_en_in     = 1'b1;
        rf_if.rd_addr_in   = 5'd7;
        rf_if.rd_in        = 32'h22222222;
        rf_if.rs_1_addr_in = 5'd7;
        rf_if.rs_2_addr_in = 5'd5;
        #1;
        vectors++;
        if (rf_if.rs_1_out !== exp_same) begin
            miscompares++;
            $display("FAIL x7_same_cycle got %h exp %h", rf_if.rs_1_out, exp_same);
        end
        vectors++;
        if (rf_if.rs_2_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL other_port_unaffected got %h exp %h", rf_if.rs_2_out, 32'hDEADBEEF);
        end
        @(posedge clk);
        #1;
        rf_if.wr_en_in = 1'b0;
        #1;
        vectors++;
        if (rf_if.rs_1_out !== 32'h22222222) begin
            miscompares++;
            $display("FAIL x7_next_cycle got %h exp %h", rf_if.rs_1_out, 32'h22222222);
        end
        $display("same_cycle: x7 11111111->22222222, next-cycle rs1=%h", rf_if.rs_1_out);
    endtask

    task automatic test_wr_en_low;
        write_cycle(5'd31, 32'hCAFEF00D, 1'b1);
        rf_if.wr_en_in     = 1'b0;
        rf_if.rd_addr_in   = 5'd31;
        rf_if.rd_in        = 32'h00000001;
        rf_if.rs_1_addr_in = 5'd31;
        #1;
        vectors++;
        if (rf_if.rs_1_out !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL x31_en_low_same got %h exp %h", rf_if.rs_1_out, 32'hCAFEF00D);
        end
        write_cycle(5'd31, 32'h00000001, 1'b0);
        #1;
        vectors++;
        if (rf_if.rs_1_out !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL x31_en_low_after got %h exp %h", rf_if.rs_1_out, 32'hCAFEF00D);
        end
        $display("wr_en_low: x31 held at %h", rf_if.rs_1_out);
    endtask

    task automatic test_all_regs;
        for (int i = 1; i < 32; i++) begin
            write_cycle(5'(i), 32'(i), 1'b1);
        end
        for (int i = 1; i < 32; i++) begin
            rf_if.rs_1_addr_in = 5'(i);
            rf_if.rs_2_addr_in = 5'(32 - i);
            #1;
            vectors++;
            if (rf_if.rs_1_out !== 32'(i)) begin
                miscompares++;
                $display("FAIL all_regs_rs1[%0d] got %h exp %h", i, rf_if.rs_1_out, 32'(i));
            end
            vectors++;
            if (rf_if.rs_2_out !== 32'(32 - i)) begin
                miscompares++;
                $display("FAIL all_regs_rs2[%0d] got %h exp %h", 32 - i, rf_if.rs_2_out, 32'(32 - i));
            end
        end
        $display("all_regs: x1..x31 written with index and read back on both ports");
    endtask

    task automatic test_reset_priority;
        rst = 1'b1;
        rf_if.wr_en_in   = 1'b1;
        rf_if.rd_addr_in = 5'd3;
        rf_if.rd_in      = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rf_if.wr_en_in     = 1'b0;
        rf_if.rs_1_addr_in = 5'd3;
        rf_if.rs_2_addr_in = 5'd31;
        #1;
        vectors++;
        if (rf_if.rs_1_out !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_prio_x3 got %h exp %h", rf_if.rs_1_out, 32'h0);
        end
        vectors++;
        if (rf_if.rs_2_out !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset_x31 got %h exp %h", rf_if.rs_2_out, 32'h0);
        end
        // First edge with reset low must accept writes again.
        write_cycle(5'd3, 32'hA5A5A5A5, 1'b1);
        #1;
        vectors++;
        if (rf_if.rs_1_out !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL resume_x3 got %h exp %h", rf_if.rs_1_out, 32'hA5A5A5A5);
        end
        $display("reset_priority: x3 cleared then rewritten, rs1=%h", rf_if.rs_1_out);
    endtask

    initial begin
        rf_if.rs_1_addr_in = '0;
        rf_if.rs_2_addr_in = '0;
        rf_if.rd_addr_in   = '0;
        rf_if.wr_en_in     = 1'b0;
        rf_if.rd_in        = '0;
        test_reset();
        test_write_read();
        test_x0();
        test_same_cycle();
        test_wr_en_low();
        test_all_regs();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/msrv32_integer_file.md
MSRV32_INTEGER_FILE -- requirements
Module: msrv32_integer_file

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ms_riscv32_mp_clk_in  input  1  rising-edge clock for all state.
REQ-002 ms_riscv32_mp_rst_in  input  1  synchronous active-high reset, sampled on rising clock edge.
REQ-003 rs_1_addr_in  input  5  read port 1 register index.
REQ-004 rs_2_addr_in  input  5  read port 2 register index.
REQ-005 rd_addr_in  input  5  write-port destination index.
REQ-006 wr_en_in  input  1  write enable, qualified by the writeback stage.
REQ-007 rd_in  input  32  writeback data from the writeback mux output.
REQ-008 rs_1_out  output  32  read data, port 1.
REQ-009 rs_2_out  output  32  read data, port 2.

Function
REQ-010 Storage SHALL be 31 x 32-bit registers for x1..x31; x0 SHALL have no storage and SHALL always read 32'h0.
REQ-011 On a rising edge with reset low, wr_en_in=1 and rd_addr_in!=0, the block SHALL load rd_in into register rd_addr_in; all other registers hold.
REQ-012 A write with rd_addr_in=0 SHALL be discarded with no state change.
REQ-013 A write with wr_en_in=0 SHALL cause no state change, whatever rd_addr_in and rd_in hold.
REQ-014 Read ports SHALL be combinational from address to data, with zero-cycle latency.
REQ-015 Both ports SHALL be readable in the same cycle, including at the same index, and SHALL return identical data at the same index.
REQ-016 A read and a write to the same index in the same cycle SHALL follow REQ-023 and REQ-024.
REQ-017 Any read at index 0 SHALL return 32'h0, including when a write to index 0 is presented in the same cycle.
REQ-018 No output SHALL be X or Z after the first reset edge.

Reset
REQ-019 While ms_riscv32_mp_rst_in=1 at a rising edge, every register x1..x31 SHALL be cleared to 32'h0.
REQ-020 Reset SHALL take priority over a simultaneous write, and that write SHALL be lost.
REQ-021 While reset is high, rs_1_out and rs_2_out SHALL reflect stored contents with bypass suppressed, so they read 32'h0 after the first reset edge.
REQ-022 A reset asserted mid-program SHALL clear all registers on that edge, and writes SHALL resume on the first edge with reset low.

Configuration
REQ-023 With macro MSRV32_RF_WRITE_BYPASS_EN defined: when wr_en_in=1, rd_addr_in!=0, reset is low and a read index equals rd_addr_in, that port SHALL output rd_in in the same cycle (write-through).
REQ-024 With MSRV32_RF_WRITE_BYPASS_EN undefined: same-cycle read of the index being written SHALL return the old stored value, and the new value SHALL be visible from the cycle after the write edge.
REQ-025 The macro SHALL affect only the read-data path; the write and reset behaviour SHALL be identical in both builds.

Verification
REQ-026 Reset then read all 32 indices on both ports -> every read returns 32'h0.
REQ-027 Write x5=32'hDEADBEEF, next cycle read rs_1=5, rs_2=5 -> both ports return 32'hDEADBEEF.
REQ-028 Write x0=32'hFFFFFFFF, then read rs_1=0 in the same and next cycle -> 32'h0 in both cycles.
REQ-029 x7 holds 32'h11111111; write x7=32'h22222222 while reading rs_1=7 -> 32'h22222222 in the same cycle with the bypass macro, 32'h11111111 without it; 32'h22222222 next cycle in both builds.
REQ-030 Assert reset together with wr_en_in=1, rd_addr_in=3, rd_in=32'hA5A5A5A5 -> x3 reads 32'h0 after the edge.
REQ-031 Write x31=32'h1 with wr_en_in=0 -> x31 unchanged; then write x1..x31 with index values -> each index reads back its own value.
